video_capture_writer: RTL and testbench

VIDEO_CAPTURE_WRITER -- requirements
Module: video_capture_writer

---
 rtl/video_capture_writer_pkg.sv | 24 ++
 rtl/capture_window.sv | 63 ++++++
 rtl/video_capture_writer.sv | 156 +++++++++++++++
 tb/tb_video_capture_writer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/video_capture_writer_pkg.sv
// Shared video capture config: default capture window, FSM encoding, line length helper.
// The reader side imports the same package so both agree on the RAM layout.
package video_capture_writer_pkg;

  localparam int DEF_H_CAPTURE_START = 0;
  localparam int DEF_H_CAPTURE_END   = 720;
  localparam int DEF_V_CAPTURE_START = 0;
  localparam int DEF_V_CAPTURE_END   = 480;
  localparam int DEF_FIELD0_END      = 240;
  localparam int DEF_FIELD1_START    = 263;
  localparam int DEF_LINE_SLOTS      = 16;
  localparam int DEF_TRIGGER_LINES   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LINES,
    ST_TRIGGERED
  } cap_state_e;

  function automatic int line_len(input int h_start, input int h_end);
    return h_end - h_start;
  endfunction

endpackage

// File: rtl/capture_window.sv
// Registered raster decode: in-window, field, end-of-line and frame/field start flags.
module capture_window
  import video_capture_writer_pkg::*;
#(
  parameter int CNT_WIDTH       = 12,
  parameter int H_CAPTURE_START = DEF_H_CAPTURE_START,
  parameter int H_CAPTURE_END   = DEF_H_CAPTURE_END,
  parameter int V_CAPTURE_START = DEF_V_CAPTURE_START,
  parameter int V_CAPTURE_END   = DEF_V_CAPTURE_END,
  parameter int FIELD0_END      = DEF_FIELD0_END,
  parameter int FIELD1_START    = DEF_FIELD1_START
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CNT_WIDTH-1:0] counterX,
  input  logic [CNT_WIDTH-1:0] counterY,
  input  logic                 interlaced,
  output logic                 in_win,
  output logic                 fld,
  output logic                 last_px,
  output logic                 frame_start,
  output logic                 field_start,
  output logic [CNT_WIDTH-1:0] xoff
);
  localparam logic [CNT_WIDTH:0]   HS  = (CNT_WIDTH+1)'(H_CAPTURE_START);
  localparam logic [CNT_WIDTH:0]   VS  = (CNT_WIDTH+1)'(V_CAPTURE_START);
  localparam logic [CNT_WIDTH-1:0] HE  = CNT_WIDTH'(H_CAPTURE_END);
  localparam logic [CNT_WIDTH-1:0] HL  = CNT_WIDTH'(H_CAPTURE_END - 1);
  localparam logic [CNT_WIDTH-1:0] VE  = CNT_WIDTH'(V_CAPTURE_END);
  localparam logic [CNT_WIDTH-1:0] F0E = CNT_WIDTH'(FIELD0_END);
  localparam logic [CNT_WIDTH-1:0] F1S = CNT_WIDTH'(FIELD1_START);

  // lower bounds via borrow bit so a zero start never becomes a constant compare
  logic [CNT_WIDTH:0] dx, dy;
  logic h_ok, p_ok, f0, f1, win_c;

  assign dx    = {1'b0, counterX} - HS;
  assign dy    = {1'b0, counterY} - VS;
  assign h_ok  = !dx[CNT_WIDTH] && (counterX < HE);
  assign p_ok  = !dy[CNT_WIDTH] && (counterY < VE);
  assign f0    = counterY < F0E;
  assign f1    = (counterY >= F1S) && (counterY < VE);
  assign win_c = h_ok && (interlaced ? (f0 || f1) : p_ok);

  always_ff @(posedge clock) begin
    if (reset) begin
      in_win      <= 1'b0;
      fld         <= 1'b0;
      last_px     <= 1'b0;
      frame_start <= 1'b0;
      field_start <= 1'b0;
      xoff        <= '0;
    end else begin
      in_win      <= win_c;
      fld         <= interlaced && f1;
      last_px     <= counterX == HL;
      frame_start <= (counterX == '0) && (counterY == '0);
      field_start <= interlaced && (counterX == '0) && (counterY == F1S);
      xoff        <= dx[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/video_capture_writer.sv
// Writes the captured raster window into a ring of line slots and pulses
// starttrigger once TRIGGER_LINES lines of the frame/field are in RAM.
module video_capture_writer
  import video_capture_writer_pkg::*;
#(
  parameter int DATA_WIDTH      = 24,
  parameter int ADDR_WIDTH      = 14,
  parameter int CNT_WIDTH       = 12,
  parameter int H_CAPTURE_START = DEF_H_CAPTURE_START,
  parameter int H_CAPTURE_END   = DEF_H_CAPTURE_END,
  parameter int V_CAPTURE_START = DEF_V_CAPTURE_START,
  parameter int V_CAPTURE_END   = DEF_V_CAPTURE_END,
  parameter int FIELD0_END      = DEF_FIELD0_END,
  parameter int FIELD1_START    = DEF_FIELD1_START,
  parameter int LINE_SLOTS      = DEF_LINE_SLOTS,
  parameter int TRIGGER_LINES   = DEF_TRIGGER_LINES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pixel,
  input  logic [CNT_WIDTH-1:0]  counterX,
  input  logic [CNT_WIDTH-1:0]  counterY,
  input  logic                  line_doubler,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] wrdata,
  output logic [ADDR_WIDTH-1:0] wraddr,
  output logic                  wren,
  output logic                  starttrigger,
  output logic                  field
);
  localparam int LINE_LEN = line_len(H_CAPTURE_START, H_CAPTURE_END);
  localparam int SLOT_W   = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;
  localparam int LCNT_W   = $clog2(TRIGGER_LINES + 1);
  localparam int STAGES   = 2;

  if (longint'(LINE_SLOTS) * LINE_LEN > (longint'(1) << ADDR_WIDTH)) begin : g_addr_check
    $error("LINE_SLOTS*LINE_LEN does not fit in ADDR_WIDTH");
  end

  // mode is sampled at frame start; the frame-start pixel itself already uses the new mode
  logic frame_in, en_q, ld_q, en_eff, ld_eff;
  assign frame_in = (counterX == '0) && (counterY == '0);
  assign en_eff   = frame_in ? enable : en_q;
  assign ld_eff   = frame_in ? line_doubler : ld_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q <= 1'b0;
      ld_q <= 1'b0;
    end else if (frame_in) begin
      en_q <= enable;
      ld_q <= line_doubler;
    end
  end

  logic                 s1_win, s1_fld, s1_last, s1_frame, s1_field;
  logic [CNT_WIDTH-1:0] s1_xoff;
  logic [DATA_WIDTH-1:0] s1_pix;
  logic [STAGES-1:0]    vld_pipe;

  capture_window #(
    .CNT_WIDTH      (CNT_WIDTH),
    .H_CAPTURE_START(H_CAPTURE_START),
    .H_CAPTURE_END  (H_CAPTURE_END),
    .V_CAPTURE_START(V_CAPTURE_START),
    .V_CAPTURE_END  (V_CAPTURE_END),
    .FIELD0_END     (FIELD0_END),
    .FIELD1_START   (FIELD1_START)
  ) u_win (
    .clock      (clock),
    .reset      (reset),
    .counterX   (counterX),
    .counterY   (counterY),
    .interlaced (ld_eff),
    .in_win     (s1_win),
    .fld        (s1_fld),
    .last_px    (s1_last),
    .frame_start(s1_frame),
    .field_start(s1_field),
    .xoff       (s1_xoff)
  );

  logic wr1;
  assign wr1  = vld_pipe[0] && s1_win;
  assign wren = vld_pipe[1];

  logic [SLOT_W-1:0]     slot, slot_base, slot_n;
  logic [ADDR_WIDTH-1:0] addr_c;

  always_comb begin
    slot_base = (s1_frame || s1_field) ? '0 : slot;
    slot_n    = slot_base;
    if (wr1 && s1_last)
      slot_n = (slot_base == SLOT_W'(LINE_SLOTS - 1)) ? '0 : slot_base + SLOT_W'(1);
  end

  assign addr_c = ADDR_WIDTH'(slot_base) * ADDR_WIDTH'(LINE_LEN) + ADDR_WIDTH'(s1_xoff);

  cap_state_e        state, state_n;
  logic [LCNT_W-1:0] lines, lines_n;
  logic              trig_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      lines <= '0;
    end else begin
      state <= state_n;
      lines <= lines_n;
    end
  end

  // restart first, then count the line that may complete in the same cycle
  always_comb begin
    state_n = state;
    lines_n = lines;
    trig_n  = 1'b0;
    if (s1_frame) begin
      state_n = vld_pipe[0] ? ST_WAIT_LINES : ST_IDLE;
      lines_n = '0;
    end else if (s1_field && state != ST_IDLE) begin
      state_n = ST_WAIT_LINES;
      lines_n = '0;
    end
    if (state_n == ST_WAIT_LINES && wr1 && s1_last) begin
      lines_n = lines_n + LCNT_W'(1);
      if (lines_n == LCNT_W'(TRIGGER_LINES)) begin
        state_n = ST_TRIGGERED;
        trig_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe     <= '0;
      s1_pix       <= '0;
      slot         <= '0;
      wrdata       <= '0;
      wraddr       <= '0;
      starttrigger <= 1'b0;
      field        <= 1'b0;
    end else begin
      vld_pipe     <= {wr1, en_eff};
      s1_pix       <= pixel;
      slot         <= slot_n;
      starttrigger <= trig_n;
      if (wr1) begin
        wrdata <= s1_pix;
        wraddr <= addr_c;
        field  <= s1_fld;
      end
    end
  end

endmodule

// File: tb/tb_video_capture_writer.sv
// Directed raster bench: each line is a sparse set of columns around the window edges.
module tb_video_capture_writer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] pixel = '0;
  logic [11:0] counterX = '0, counterY = '0;
  logic        line_doubler = 1'b0, enable = 1'b0;
  logic [23:0] wrdata;
  logic [13:0] wraddr;
  logic        wren, starttrigger, field;

  video_capture_writer dut (
    .clock(clock), .reset(reset), .pixel(pixel), .counterX(counterX), .counterY(counterY),
    .line_doubler(line_doubler), .enable(enable), .wrdata(wrdata), .wraddr(wraddr),
    .wren(wren), .starttrigger(starttrigger), .field(field)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  int xl[11] = '{0, 1, 2, 100, 300, 301, 718, 719, 720, 721, 857};
  int px = -1, py = -1, ox = -1, oy = -1;
  int nwr, nbad, ntrig, d300_5;
  int tx[4], ty[4], twr[4];
  int a0[525], a719[525], w0[525], f0[525];

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    nwr = 0; nbad = 0; ntrig = 0; d300_5 = -1;
    for (int i = 0; i < 4; i++) begin tx[i] = -1; ty[i] = -1; twr[i] = -1; end
    for (int i = 0; i < 525; i++) begin a0[i] = -1; a719[i] = -1; w0[i] = -1; f0[i] = -1; end
  endtask

  // outputs after an edge belong to the input driven one step earlier
  task automatic step(input int x, input int y);
    counterX = 12'(x);
    counterY = 12'(y);
    pixel    = {12'(y), 12'(x)};
    @(posedge clock); #1;
    ox = px; oy = py; px = x; py = y;
    if (wren) begin
      nwr++;
      if (ox >= 720 || oy >= 480) nbad++;
    end
    if (starttrigger) begin
      if (ntrig < 4) begin tx[ntrig] = ox; ty[ntrig] = oy; twr[ntrig] = int'(wren); end
      ntrig++;
    end
    if (oy >= 0 && oy < 525) begin
      if (ox == 0) begin a0[oy] = int'(wraddr); w0[oy] = int'(wren); f0[oy] = int'(field); end
      if (ox == 719 && wren) a719[oy] = int'(wraddr);
      if (ox == 300 && oy == 5 && wren) d300_5 = int'(wrdata);
    end
  endtask

  task automatic run_frame(input bit l, input bit e, input int tog_y, input int rst_y);
    clear_stats();
    for (int y = 0; y < 525; y++) begin
      for (int i = 0; i < 11; i++) begin
        if (y == 0 && i == 0) begin line_doubler = l; enable = e; end
        if (y == tog_y && xl[i] == 100) begin line_doubler = ~line_doubler; enable = ~enable; end
        reset = (y == rst_y && xl[i] == 300);
        step(xl[i], y);
        if (reset) begin
          chk("rst_mid_wren", wren, 0);
          nwr = 0;
          reset = 1'b0;
        end
      end
    end
  endtask

  initial begin
    clear_stats();
    for (int i = 0; i < 3; i++) step(857, 524);
    chk("rst_wren", wren, 0);
    chk("rst_wrdata", wrdata, 0);
    chk("rst_wraddr", wraddr, 0);
    chk("rst_trig", starttrigger, 0);
    chk("rst_field", field, 0);
    reset = 1'b0;
    step(857, 524);
    chk("idle_wren", wren, 0);

    // progressive frame
    run_frame(1'b0, 1'b1, -1, -1);
    chk("p_first_wren", w0[0], 1);
    chk("p_addr_0_0", a0[0], 0);
    chk("p_addr_719_0", a719[0], 719);
    chk("p_addr_0_1", a0[1], 720);
    chk("p_addr_719_15", a719[15], 11519);
    chk("p_addr_0_16", a0[16], 0);
    chk("p_wrdata_300_5", d300_5, 24'h005_12C);
    chk("p_nwr", nwr, 3840);
    chk("p_outside", nbad, 0);
    chk("p_ntrig", ntrig, 1);
    chk("p_trig_x", tx[0], 719);
    chk("p_trig_y", ty[0], 1);
    chk("p_trig_wren", twr[0], 1);
    chk("p_field", f0[100], 0);

    // interlaced frame
    run_frame(1'b1, 1'b1, -1, -1);
    chk("i_addr_0_239", a0[239], 10800);
    chk("i_field_239", f0[239], 0);
    chk("i_wren_250", w0[250], 0);
    chk("i_addr_0_263", a0[263], 0);
    chk("i_wren_263", w0[263], 1);
    chk("i_field_263", f0[263], 1);
    chk("i_ntrig", ntrig, 2);
    chk("i_trig0_y", ty[0], 1);
    chk("i_trig1_y", ty[1], 264);
    chk("i_trig1_x", tx[1], 719);
    chk("i_nwr", nwr, 3656);

    // mid-frame toggle of both controls: progressive capture continues
    run_frame(1'b0, 1'b1, 50, -1);
    chk("t_wren_250", w0[250], 1);
    chk("t_field_250", f0[250], 0);
    chk("t_nwr", nwr, 3840);
    chk("t_ntrig", ntrig, 1);

    // frame with enable latched low
    run_frame(1'b1, 1'b0, -1, -1);
    chk("off_nwr", nwr, 0);
    chk("off_ntrig", ntrig, 0);

    // reset pulse mid-frame, then a clean frame
    run_frame(1'b0, 1'b1, -1, 10);
    chk("r_nwr_after", nwr, 0);
    run_frame(1'b0, 1'b1, -1, -1);
    chk("r_next_wren", w0[0], 1);
    chk("r_next_addr", a0[0], 0);
    chk("r_next_nwr", nwr, 3840);
    chk("r_next_ntrig", ntrig, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
